// File: rtl/timer_cmp.sv
// timer_cmp: 64-bit compare/interrupt unit on the timer's cycle count, with one-shot or periodic reload.
// Latency: bus access fires in the 2nd valid cycle; irq rises the cycle after a match. Backpressure: ready is held low on the 1st valid cycle and after each fire.
module timer_cmp #(
    parameter logic [63:0] RESET_CMP    = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [63:0] RESET_PERIOD = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] count,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        irq
);

    localparam logic [2:0] IDX_CMP_LO = 3'd0;
    localparam logic [2:0] IDX_CMP_HI = 3'd1;
    localparam logic [2:0] IDX_PER_LO = 3'd2;
    localparam logic [2:0] IDX_PER_HI = 3'd3;
    localparam logic [2:0] IDX_CTRL   = 3'd4;
    localparam logic [2:0] IDX_STATUS = 3'd5;
    localparam logic [2:0] IDX_CNT_LO = 3'd6;
    localparam logic [2:0] IDX_CNT_HI = 3'd7;

    logic [63:0] cmp;
    logic [63:0] period;
    logic        enable;
    logic        periodic;
    logic        irq_en;
    logic        pending;
    logic [31:0] cnt_hi_latch;
    logic        hs;

    logic [63:0] cmp_nxt;
    logic [63:0] period_nxt;
    logic        enable_nxt;
    logic        periodic_nxt;
    logic        irq_en_nxt;
    logic        pending_nxt;
    logic [31:0] cnt_hi_latch_nxt;

    logic [2:0]  idx;
    logic        fire;
    logic        wr_fire;
    logic        rd_fire;
    logic        match;
    logic        reload;
    logic [31:0] rd_mux;
    logic        unused_addr;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign idx         = addr[4:2];
    assign unused_addr = ^{addr[31:5], addr[1:0]};

    assign ready   = hs & valid;
    assign fire    = valid & ready;
    assign wr_fire = fire & (|wstrb);
    assign rd_fire = fire & ~(|wstrb);

    assign match  = enable & (count >= cmp);
    assign reload = periodic & (period != 64'd0);

    assign irq = pending & irq_en;

    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            IDX_CMP_LO: rd_mux = cmp[31:0];
            IDX_CMP_HI: rd_mux = cmp[63:32];
            IDX_PER_LO: rd_mux = period[31:0];
            IDX_PER_HI: rd_mux = period[63:32];
            IDX_CTRL:   rd_mux = {29'd0, irq_en, periodic, enable};
            IDX_STATUS: rd_mux = {31'd0, pending};
            IDX_CNT_LO: rd_mux = count[31:0];
            IDX_CNT_HI: rd_mux = cnt_hi_latch;
            default:    rd_mux = 32'd0;
        endcase
    end

    // Read data reflects pre-write state because it is muxed from the current registers.
    assign rdata = ready ? rd_mux : 32'd0;

    always_comb begin
        cmp_nxt          = cmp;
        period_nxt       = period;
        enable_nxt       = enable;
        periodic_nxt     = periodic;
        irq_en_nxt       = irq_en;
        pending_nxt      = pending;
        cnt_hi_latch_nxt = cnt_hi_latch;

        if (match) begin
            if (reload) begin
                cmp_nxt = cmp + period;
            end else begin
                enable_nxt = 1'b0;
            end
        end

        // Bus writes are applied after the match update so the bus wins on collisions.
        if (wr_fire) begin
            case (idx)
                IDX_CMP_LO: cmp_nxt[31:0]    = merge_bytes(cmp_nxt[31:0], wdata, wstrb);
                IDX_CMP_HI: cmp_nxt[63:32]   = merge_bytes(cmp_nxt[63:32], wdata, wstrb);
                IDX_PER_LO: period_nxt[31:0] = merge_bytes(period[31:0], wdata, wstrb);
                IDX_PER_HI: period_nxt[63:32] = merge_bytes(period[63:32], wdata, wstrb);
                IDX_CTRL: begin
                    if (wstrb[0]) begin
                        enable_nxt   = wdata[0];
                        periodic_nxt = wdata[1];
                        irq_en_nxt   = wdata[2];
                    end
                end
                IDX_STATUS: begin
                    if (wstrb[0] && wdata[0]) begin
                        pending_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (match) begin
            pending_nxt = 1'b1;
        end

        if (rd_fire && (idx == IDX_CNT_LO)) begin
            cnt_hi_latch_nxt = count[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp          <= RESET_CMP;
            period       <= RESET_PERIOD;
            enable       <= 1'b0;
            periodic     <= 1'b0;
            irq_en       <= 1'b0;
            pending      <= 1'b0;
            cnt_hi_latch <= 32'd0;
            hs           <= 1'b0;
        end else begin
            cmp          <= cmp_nxt;
            period       <= period_nxt;
            enable       <= enable_nxt;
            periodic     <= periodic_nxt;
            irq_en       <= irq_en_nxt;
            pending      <= pending_nxt;
            cnt_hi_latch <= cnt_hi_latch_nxt;
            hs           <= valid & ~ready;
        end
    end

endmodule

// File: doc/timer_cmp.md
Name: timer_cmp

Overview:
Memory-mapped compare/interrupt unit that consumes the free-running 64-bit cycle count produced by the system timer. It holds a 64-bit compare value and an optional reload period, and raises a level interrupt when the count reaches the compare value. It sits on the same valid/ready peripheral bus as the timer, and its irq output feeds the core's timer-interrupt input.

Parameters:
RESET_CMP, 64'hFFFF_FFFF_FFFF_FFFF, compare value after reset (no match until written).
RESET_PERIOD, 64'd0, reload period after reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
count  input  64  free-running cycle count from the timer; treated as unsigned.
valid  input  1  bus request; held high until ready is seen.
ready  output  1  one-cycle transaction-complete pulse.
addr  input  32  byte address; addr[4:2] selects the register; all other bits are ignored.
rdata  output  32  read data; valid only while ready=1, otherwise 0.
wdata  input  32  write data.
wstrb  input  4  byte enables; wstrb=0 means a read.
irq  output  1  interrupt level, equal to pending AND irq_en.

Behaviour:
- Reset: cmp=RESET_CMP, period=RESET_PERIOD, enable=0, periodic=0, irq_en=0, pending=0, cnt_hi_latch=0, hs=0. Outputs ready=0, rdata=0, irq=0.
- Handshake:
  - hs <= valid & ~ready; ready = hs & valid.
  - ready rises in the 2nd cycle of valid. A transaction completes on valid & ready (the "fire" cycle).
  - If valid stays high after fire, ready is 0 for the following cycle and the next transaction fires one cycle later. Minimum spacing is 2 cycles per transaction.
  - Dropping valid before ready aborts the request with no side effects.
- Register map (word index = addr[4:2]):
  - 0 CMP_LO (RW), cmp[31:0].
  - 1 CMP_HI (RW), cmp[63:32].
  - 2 PER_LO (RW), period[31:0].
  - 3 PER_HI (RW), period[63:32].
  - 4 CTRL (RW): bit0 enable, bit1 periodic, bit2 irq_en; other bits read 0.
  - 5 STATUS: bit0 pending; writing 1 to bit0 clears it (W1C); writing 0 has no effect.
  - 6 CNT_LO (RO): returns count[31:0]; on a read fire, cnt_hi_latch <= count[63:32] from the same cycle.
  - 7 CNT_HI (RO): returns cnt_hi_latch, giving an atomic 64-bit read when CNT_LO is read first.
- Writes:
  - Applied on the fire cycle with per-byte wstrb; bytes whose strobe is 0 keep their value.
  - Writes to index 6 and 7 are ignored, and the CNT_LO side effect does not occur.
  - rdata on a write fire returns the pre-write register value.
- Match:
  - Evaluated every cycle as enable & (count >= cmp), a 64-bit unsigned comparison on the current registered values.
  - On match: pending <= 1, so irq rises the cycle after the first matching cycle.
  - One-shot (periodic=0, or period==0): enable <= 0 on the same edge.
  - Periodic (periodic=1 and period!=0): cmp <= cmp + period, modulo 2^64 with wrap-around; enable stays 1. If the count is still >= the new cmp, the match fires again on the next cycle (catch-up), one reload per cycle.
- Simultaneous events:
  - A bus write to CMP_LO/CMP_HI in a match cycle: the bus bytes win over the reload, and pending is still set.
  - A write to CTRL in a match cycle: the bus value of enable wins over the one-shot clear.
  - A W1C to STATUS in a match cycle: the set wins, and pending stays 1.
- Reset asserted mid-transaction: all state returns to reset values on that edge and the transaction is dropped; ready is 0 in the cycle after reset.

Test Plan:
1. Reset, then read all 8 words (count at 100) -> CMP_LO=CMP_HI=FFFFFFFF, PER_*=0, CTRL=0, STATUS=0, CNT_LO=100 + read-cycle offset; ready is high in exactly the 2nd valid cycle of each read.
2. Write CMP=0x0000_0001_0000_0010, CTRL=0x5, with count driven from 0x0000_0001_0000_0000 -> pending and irq rise the cycle after count=0x1_0000_0010; enable reads 0 afterwards; W1C STATUS=1 clears irq.
3. Periodic mode: cmp=50, period=20, CTRL=0x7 -> irq set at count 50; after clearing, set again at 70 and at 90. Periodic with period=0 behaves as one-shot.
4. Wrap: cmp=0xFFFF_FFFF_FFFF_FFF0, period=0x20, periodic -> after the match, cmp reads 0x10 (mod 2^64).
5. Byte strobes: write CMP_LO with wdata=0xAABBCCDD, wstrb=4'b0101 over 0x11223344 -> reads 0x11BB33DD. A write to CNT_LO changes nothing.
6. Collisions: a W1C in the same cycle as a new match -> pending=1. A CMP_LO write in a periodic match cycle -> cmp[31:0] equals the written value, not the reload. Reset asserted while valid is high -> ready=0 and all registers are at their defaults the next cycle.
